// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: opcode values, field bounds,
// the halt sentinel and the fetch FSM states.
package fetch_unit_pkg;

    localparam logic [5:0]  OPCODE_JUMP = 6'b000000;
    localparam logic [5:0]  OPCODE_ADD  = 6'b000001;
    localparam logic [5:0]  OPCODE_LW   = 6'b010001;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int TARGET_HI = 25;
    localparam int TARGET_LO = 0;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_predecode.sv
// Combinational predecode of the fetched word: flags JUMP and the halt sentinel
// and forms the in-region jump target.
module fetch_predecode
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] HALT_VALUE = fetch_unit_pkg::HALT_WORD
) (
    input  logic [31:0] instr_in,
    input  logic [5:0]  pc_hi,
    output logic        is_jump,
    output logic        is_halt,
    output logic [31:0] jump_target
);

    always_comb begin
        is_jump     = (instr_in[OPCODE_HI:OPCODE_LO] == OPCODE_JUMP);
        is_halt     = (instr_in == HALT_VALUE);
        // Target keeps the current 64M-word region of the PC.
        jump_target = {pc_hi, instr_in[TARGET_HI:TARGET_LO]};
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures code-memory words into IF/ID,
// resolves JUMPs early and stops on the halt sentinel or an out-of-range PC.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | fetching; redirect > stall > range/halt check > jump > fetch
// HALT  | fetch stopped; only a redirect restarts, stall ignored
module fetch_unit #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] HALT_WORD = fetch_unit_pkg::HALT_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);
    import fetch_unit_pkg::*;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         is_jump;
    logic         is_halt;
    logic [31:0]  jump_target;

    fetch_predecode #(
        .HALT_VALUE (HALT_WORD)
    ) u_predecode (
        .instr_in    (instr_in),
        .pc_hi       (pc[31:26]),
        .is_jump     (is_jump),
        .is_halt     (is_halt),
        .jump_target (jump_target)
    );

    assign pc_out = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc    <= 32'd0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        pc          <= redirect_pc;
                        if_id_valid <= 1'b0;
                    end else if (stall) begin
                        pc          <= pc;
                    end else if ((pc >= MEM_LIMIT) || is_halt) begin
                        // Range check precedes the fetch, so a wrapped PC never issues.
                        state       <= HALT;
                        halted      <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else if (is_jump) begin
                        pc          <= jump_target;
                        if_id_valid <= 1'b0;
                    end else begin
                        if_id_instr <= instr_in;
                        if_id_pc    <= pc;
                        if_id_valid <= 1'b1;
                        pc          <= pc + 32'd1;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                HALT: begin
                    if_id_valid <= 1'b0;
                    if (redirect_valid) begin
                        state  <= RUN;
                        halted <= 1'b0;
                        pc     <= redirect_pc;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a combinational code memory model, hand-computed
// expectations for straight-line, stall, jump, redirect, halt and async reset.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];
    int n_checks;
    int n_errors;

    fetch_unit #(
        .MEM_DEPTH (256),
        .RESET_PC  (32'd0),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_in       (instr_in),
        .pc_out         (pc_out),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        instr_in = 32'd0;
        if (pc_out < 32'd256) instr_in = mem[pc_out[7:0]];
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] add_word(input int i);
        return {OPCODE_ADD, 26'(i)};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = add_word(i);
        mem[5]  = {OPCODE_LW, 26'h0000_123};
        mem[12] = 32'h0000_0000;
        mem[17] = 32'hFFFF_FFFF;

        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        #12;
        check32("reset_pc", pc_out, 32'd0);
        check32("reset_valid", {31'd0, if_id_valid}, 32'd0);
        check32("reset_halted", {31'd0, halted}, 32'd0);
        check32("reset_count", fetch_count, 32'd0);
        check32("reset_instr", if_id_instr, 32'd0);
        rst = 1'b0;

        // Straight line: pc 0..5, IF/ID trails by one
        for (int i = 0; i < 5; i++) begin
            check32("line_pc", pc_out, 32'(i));
            step();
            check32("line_ifid_pc", if_id_pc, 32'(i));
            check32("line_valid", {31'd0, if_id_valid}, 32'd1);
            check32("line_instr", if_id_instr, add_word(i));
        end
        check32("line_count", fetch_count, 32'd5);

        // LW at 5, then one stall cycle at pc=6
        step();
        check32("lw_pc", pc_out, 32'd6);
        stall = 1'b1;
        step();
        check32("stall_pc", pc_out, 32'd6);
        check32("stall_ifid_pc", if_id_pc, 32'd5);
        check32("stall_instr", if_id_instr, {OPCODE_LW, 26'h0000_123});
        check32("stall_valid", {31'd0, if_id_valid}, 32'd1);
        check32("stall_count", fetch_count, 32'd6);
        stall = 1'b0;
        step();
        check32("post_stall_ifid_pc", if_id_pc, 32'd6);
        check32("post_stall_pc", pc_out, 32'd7);
        check32("post_stall_count", fetch_count, 32'd7);

        // Run to the JUMP at 12
        for (int i = 0; i < 5; i++) step();
        check32("pre_jump_pc", pc_out, 32'd12);
        check32("pre_jump_count", fetch_count, 32'd12);
        step();
        check32("jump_pc", pc_out, 32'd0);
        check32("jump_valid", {31'd0, if_id_valid}, 32'd0);
        check32("jump_count", fetch_count, 32'd12);
        step();
        check32("after_jump_ifid_pc", if_id_pc, 32'd0);
        check32("after_jump_instr", if_id_instr, add_word(0));
        check32("after_jump_valid", {31'd0, if_id_valid}, 32'd1);
        check32("after_jump_count", fetch_count, 32'd13);

        // Redirect beats stall at pc=6
        for (int i = 0; i < 5; i++) step();
        check32("pre_redir_pc", pc_out, 32'd6);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd8;
        step();
        check32("redir_pc", pc_out, 32'd8);
        check32("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check32("redir_count", fetch_count, 32'd18);
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        check32("redir_fetch_pc", if_id_pc, 32'd8);
        check32("redir_fetch_valid", {31'd0, if_id_valid}, 32'd1);
        check32("redir_next_pc", pc_out, 32'd9);
        check32("redir_fetch_count", fetch_count, 32'd19);

        // Async reset between edges at pc=9
        #2;
        rst = 1'b1;
        #1;
        check32("arst_pc", pc_out, 32'd0);
        check32("arst_valid", {31'd0, if_id_valid}, 32'd0);
        check32("arst_count", fetch_count, 32'd0);
        #2;
        rst = 1'b0;
        step();
        check32("arst_resume_ifid_pc", if_id_pc, 32'd0);
        check32("arst_resume_valid", {31'd0, if_id_valid}, 32'd1);
        check32("arst_resume_pc", pc_out, 32'd1);
        check32("arst_resume_count", fetch_count, 32'd1);

        // Halt via redirect to the sentinel at 17
        redirect_valid = 1'b1;
        redirect_pc = 32'd17;
        step();
        check32("to17_pc", pc_out, 32'd17);
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            step();
            check32("halt_flag", {31'd0, halted}, 32'd1);
            check32("halt_pc", pc_out, 32'd17);
            check32("halt_valid", {31'd0, if_id_valid}, 32'd0);
        end
        check32("halt_count", fetch_count, 32'd1);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        step();
        check32("restart_halted", {31'd0, halted}, 32'd0);
        check32("restart_pc", pc_out, 32'd0);
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        check32("restart_ifid_pc", if_id_pc, 32'd0);
        check32("restart_valid", {31'd0, if_id_valid}, 32'd1);
        check32("restart_count", fetch_count, 32'd2);

        // Out-of-range PC halts without fetching
        redirect_valid = 1'b1;
        redirect_pc = 32'd256;
        step();
        check32("oor_pc", pc_out, 32'd256);
        check32("oor_not_yet", {31'd0, halted}, 32'd0);
        redirect_valid = 1'b0;
        step();
        check32("oor_halted", {31'd0, halted}, 32'd1);
        check32("oor_pc_hold", pc_out, 32'd256);
        check32("oor_valid", {31'd0, if_id_valid}, 32'd0);
        check32("oor_count", fetch_count, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'd255;
        step();
        redirect_valid = 1'b0;
        check32("last_word_pc", pc_out, 32'd255);
        step();
        check32("last_word_ifid_pc", if_id_pc, 32'd255);
        check32("last_word_valid", {31'd0, if_id_valid}, 32'd1);
        check32("last_word_next_pc", pc_out, 32'd256);
        step();
        check32("last_word_halted", {31'd0, halted}, 32'd1);
        check32("last_word_count", fetch_count, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
